switch_led_unit: RTL and testbench



---
 rtl/sled_pkg.sv | 13 +
 rtl/switch_debounce.sv | 43 ++++
 rtl/switch_led_unit.sv | 97 +++++++++
 tb/tb_switch_led_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sled_pkg.sv
// Shared definitions for the switch/LED unit: the LED function select codes.
package sled_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_PASS   = 3'd0;
  localparam mode_t MODE_PAND   = 3'd1;
  localparam mode_t MODE_POR    = 3'd2;
  localparam mode_t MODE_PXOR   = 3'd3;
  localparam mode_t MODE_TOGGLE = 3'd4;
  localparam mode_t MODE_COUNT  = 3'd5;

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: 2-flop synchroniser followed by a consecutive-difference
// counter. The stable level only moves after DEBOUNCE_CYCLES back-to-back
// cycles of disagreement; any agreement restarts the count.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The count never holds DEBOUNCE_CYCLES itself: the edge that would reach it
  // is the edge that commits the new level and clears the counter.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronise the raw pin and filter it into the stable level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_led_unit.sv
// Switch-to-LED glue: debounces WIDTH switches and drives WIDTH LEDs from a
// runtime-selected function of the debounced levels. WIDTH must be even.
// Toggle and edge-count state run in the background in every mode, so a mode
// change never loses them.
module switch_led_unit
  import sled_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switch,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic [WIDTH-1:0] sw_stable
);

  localparam int HALF = WIDTH / 2;

  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] edge_cnt;
  logic [WIDTH-1:0] pair_and;
  logic [WIDTH-1:0] pair_or;
  logic [WIDTH-1:0] pair_xor;
  logic [WIDTH-1:0] led_next;

  genvar gi;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_deb
      switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (switch[gi]),
        .stable(sw_stable[gi])
      );
    end

    // Pair (2i, 2i+1) lands on bit i; the upper half is unused and held at 0.
    for (gi = 0; gi < HALF; gi++) begin : g_pair
      assign pair_and[gi] = sw_stable[2*gi] & sw_stable[2*gi+1];
      assign pair_or[gi]  = sw_stable[2*gi] | sw_stable[2*gi+1];
      assign pair_xor[gi] = sw_stable[2*gi] ^ sw_stable[2*gi+1];
    end
    for (gi = HALF; gi < WIDTH; gi++) begin : g_pair_hi
      assign pair_and[gi] = 1'b0;
      assign pair_or[gi]  = 1'b0;
      assign pair_xor[gi] = 1'b0;
    end
  endgenerate

  assign rise = sw_stable & ~stable_d;

  // Edge history, per-channel toggle latches and channel-0 rise counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= '0;
      toggle   <= '0;
      edge_cnt <= '0;
    end else begin
      stable_d <= sw_stable;
      toggle   <= toggle ^ rise;
      if (rise[0]) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

  // Select the LED function; reserved codes blank the LEDs.
  always_comb begin
    led_next = '0;
    case (mode_t'(mode))
      MODE_PASS:   led_next = sw_stable;
      MODE_PAND:   led_next = pair_and;
      MODE_POR:    led_next = pair_or;
      MODE_PXOR:   led_next = pair_xor;
      MODE_TOGGLE: led_next = toggle;
      MODE_COUNT:  led_next = edge_cnt;
      default:     led_next = '0;
    endcase
  end

  // Register the LED drive so the pins see glitch-free levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_switch_led_unit.sv
// Self-checking bench for switch_led_unit (WIDTH=8, DEBOUNCE_CYCLES=4).
// A time-indexed reference model predicts led/sw_stable every cycle; directed
// scenarios add fixed expected values at the points of interest.
module tb_switch_led_unit;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] switch = '0;
  logic [2:0]   mode = 3'd0;
  logic [W-1:0] led;
  logic [W-1:0] sw_stable;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable, m_prev, m_toggle, m_cnt, m_led;

  switch_led_unit #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .switch   (switch),
    .mode     (mode),
    .led      (led),
    .sw_stable(sw_stable)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_led(input int md, input logic [W-1:0] st,
                                            input logic [W-1:0] tg, input logic [W-1:0] cn);
    logic [W-1:0] r;
    r = '0;
    case (md)
      0: r = st;
      1, 2, 3: begin
        for (int i = 0; i < W / 2; i++) begin
          if (md == 1) r[i] = st[2*i] & st[2*i+1];
          else if (md == 2) r[i] = st[2*i] | st[2*i+1];
          else r[i] = st[2*i] ^ st[2*i+1];
        end
      end
      4: r = tg;
      5: r = cn;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Everything cleared; history pretends the pins read 0 forever before.
  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < D + 2; k++) hist.push_back('0);
    m_stable = '0;
    m_prev   = '0;
    m_toggle = '0;
    m_cnt    = '0;
    m_led    = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  // hist[0] is this edge's pin sample; the filter compares the samples taken
  // 2..D+1 edges ago (the synchroniser delay) against the current stable level.
  task automatic model_edge();
    logic [W-1:0] new_stable, new_led, rise;
    bit all_diff;
    if (!rst_n) return;
    new_led = ref_led(int'(mode), m_stable, m_toggle, m_cnt);
    rise = m_stable & ~m_prev;
    m_toggle = m_toggle ^ rise;
    if (rise[0]) m_cnt = m_cnt + 8'd1;
    hist.push_front(switch);
    void'(hist.pop_back());
    new_stable = m_stable;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int k = 2; k <= D + 1; k++)
        if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) new_stable[b] = ~m_stable[b];
    end
    m_prev   = m_stable;
    m_stable = new_stable;
    m_led    = new_led;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_val("led_model", led, m_led);
    check_val("stable_model", sw_stable, m_stable);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_led", led, 8'h00);
    check_val("rst_stable", sw_stable, 8'h00);
    ticks(2);
    rst_n = 1'b1;
  endtask

  // One debounced rise-then-fall on switch[0].
  task automatic pulse0();
    switch[0] = 1'b1;
    ticks(D + 2);
    switch[0] = 1'b0;
    ticks(D + 2);
  endtask

  initial begin
    model_reset();

    // Reset and latency.
    switch = '0;
    mode = 3'd0;
    do_reset();
    switch = 8'hA5;
    for (int k = 1; k <= D + 3; k++) begin
      tick();
      if (k == D + 1) check_val("lat_stable_before", sw_stable, 8'h00);
      if (k == D + 2) check_val("lat_stable", sw_stable, 8'hA5);
      if (k == D + 2) check_val("lat_led_before", led, 8'h00);
      if (k == D + 3) check_val("lat_led", led, 8'hA5);
    end
    $display("latency: sw_stable=%02h led=%02h", sw_stable, led);

    // Bounce rejection on channel 0.
    switch = '0;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      switch[0] = ~r[0];
      ticks(2);
      check_val("bounce_hold0", sw_stable, 8'h00);
    end
    switch[0] = 1'b0;
    ticks(6);
    check_val("bounce_after", sw_stable, 8'h00);
    switch[0] = 1'b1;
    ticks(D - 1);
    switch[0] = 1'b0;
    ticks(8);
    check_val("pulse_short", sw_stable, 8'h00);
    switch[0] = 1'b1;
    ticks(8);
    check_val("pulse_long", sw_stable, 8'h01);
    $display("bounce: sw_stable=%02h", sw_stable);

    // Pairwise modes on 1101_0111.
    switch = 8'hD7;
    ticks(8);
    mode = 3'd1; tick(); check_val("pand", led, 8'h09);
    mode = 3'd2; tick(); check_val("por", led, 8'h0F);
    mode = 3'd3; tick(); check_val("pxor", led, 8'h06);
    mode = 3'd6; tick(); check_val("reserved", led, 8'h00);
    $display("pairwise: last led=%02h", led);

    // Toggle latch on channel 2, retained across a mode change.
    switch = '0;
    mode = 3'd4;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      switch = 8'h04;
      ticks(D + 4);
      check_val("toggle_rise", led, (r == 1) ? 8'h00 : 8'h04);
      switch = 8'h00;
      ticks(D + 4);
    end
    mode = 3'd0; tick(); check_val("toggle_pass", led, 8'h00);
    mode = 3'd4; tick(); check_val("toggle_kept", led, 8'h04);
    $display("toggle: led=%02h", led);

    // Rising-edge counter and wrap.
    switch = '0;
    mode = 3'd5;
    do_reset();
    for (int r = 0; r < 255; r++) pulse0();
    check_val("count_ff", led, 8'hFF);
    pulse0();
    check_val("count_wrap", led, 8'h00);
    $display("count: led=%02h after wrap", led);

    // Mid-operation reset with a count in flight and toggle=0x04.
    switch = '0;
    mode = 3'd4;
    do_reset();
    switch = 8'h04; ticks(D + 4);
    switch = 8'h00; ticks(D + 4);
    check_val("mid_toggle", led, 8'h04);
    switch = 8'h02;
    ticks(D + 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("mid_rst_led", led, 8'h00);
    check_val("mid_rst_stable", sw_stable, 8'h00);
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= D + 4; k++) begin
      tick();
      if (k == 2) check_val("mid_toggle_cleared", led, 8'h00);
      if (k == D + 1) check_val("mid_stable_before", sw_stable, 8'h00);
      if (k == D + 2) check_val("mid_stable", sw_stable, 8'h02);
      if (k == D + 4) check_val("mid_toggle_new", led, 8'h02);
    end
    mode = 3'd5; tick(); check_val("mid_count_cleared", led, 8'h00);
    $display("mid-reset: sw_stable=%02h", sw_stable);

    // Randomised traffic against the model.
    for (int r = 0; r < 200; r++) begin
      switch = 8'($urandom);
      if ($urandom_range(0, 3) == 0) mode = 3'($urandom_range(0, 7));
      ticks($urandom_range(1, D + 4));
    end
    $display("random: final sw_stable=%02h led=%02h", sw_stable, led);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
